// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the EX-stage decoder and the fetch controller.
// master drives the decoded instruction class; slave returns the fetch controls.
interface fetch_ctrl_if;
    logic        valid_EX;
    logic        is_branch_EX;
    logic        taken_EX;
    logic        is_jump_EX;
    logic        is_jr_EX;
    logic        is_muldiv_EX;
    logic        reads_hilo_EX;
    logic        imem_ready;
    logic [1:0]  pc_src;
    logic        stall;
    logic        flush_EX;
    logic        muldiv_start;
    logic        muldiv_busy;
    logic        muldiv_done;
    logic [15:0] stall_count;

    modport master (
        output valid_EX, is_branch_EX, taken_EX, is_jump_EX, is_jr_EX,
               is_muldiv_EX, reads_hilo_EX, imem_ready,
        input  pc_src, stall, flush_EX, muldiv_start, muldiv_busy,
               muldiv_done, stall_count
    );

    modport slave (
        input  valid_EX, is_branch_EX, taken_EX, is_jump_EX, is_jr_EX,
               is_muldiv_EX, reads_hilo_EX, imem_ready,
        output pc_src, stall, flush_EX, muldiv_start, muldiv_busy,
               muldiv_done, stall_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch/EX pipeline controller: stall and PC-source selection, mult/div
// sequencing with HI/LO hazard stalls, wrong-path squash and a stall counter.
//
// state  | meaning
// -------+-----------------------------------------------
// RUN    | HI/LO unit idle, mult/div may be launched
// MULDIV | HI/LO unit busy, counter counts down to 0
module fetch_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6,
    parameter int DELAY_SLOT    = 1
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.slave  bus
);

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_q;
    logic               done_q, done_d;
    logic [15:0]        stall_cnt_q;

    logic               busy;
    logic               hz;
    logic               stall;
    logic [1:0]         pc_src;
    logic               redirect;
    logic               start;

    // All combinational controls are forced low while reset is asserted.
    always_comb begin
        busy     = (state_q == MULDIV);
        hz       = bus.valid_EX & (bus.reads_hilo_EX | bus.is_muldiv_EX) & busy;
        stall    = rst & (~bus.imem_ready | hz);
        pc_src   = 2'd0;
        if (rst && !stall && bus.valid_EX) begin
            if (bus.is_jr_EX)
                pc_src = 2'd3;
            else if (bus.is_jump_EX)
                pc_src = 2'd2;
            else if (bus.is_branch_EX && bus.taken_EX)
                pc_src = 2'd1;
        end
        redirect = ~stall & bus.valid_EX & (pc_src != 2'd0);
        start    = rst & ~stall & bus.valid_EX & bus.is_muldiv_EX;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (start) begin
                    state_d = MULDIV;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end
            end
            MULDIV: begin
                cnt_d  = cnt_q - CNT_W'(1);
                done_d = (cnt_q == CNT_W'(1));
                if (cnt_q == '0) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            done_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            flush_q <= (DELAY_SLOT == 0) && redirect;
            if (stall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.pc_src       = pc_src;
    assign bus.stall        = stall;
    assign bus.flush_EX     = flush_q;
    assign bus.muldiv_start = start;
    assign bus.muldiv_busy  = busy;
    assign bus.muldiv_done  = done_q;
    assign bus.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against a
// cycle-level reference model; two instances cover both delay-slot settings.
module tb_fetch_ctrl;
    localparam int MC = 4;

    // input vector layout {valid, branch, taken, jump, jr, muldiv, reads_hilo, ready}
    localparam logic [7:0] I_IDLE = 8'b0000_0001;
    localparam logic [7:0] I_V    = 8'b1000_0001;
    localparam logic [7:0] I_MD   = 8'b1000_0101;
    localparam logic [7:0] I_RH   = 8'b1000_0011;
    localparam logic [7:0] I_BRT  = 8'b1110_0001;
    localparam logic [7:0] I_JMP  = 8'b1001_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic v, br, tk, j, jr, md, rh, rdy;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl_if if0 ();
    fetch_ctrl_if if1 ();

    assign if0.valid_EX = v;      assign if1.valid_EX = v;
    assign if0.is_branch_EX = br; assign if1.is_branch_EX = br;
    assign if0.taken_EX = tk;     assign if1.taken_EX = tk;
    assign if0.is_jump_EX = j;    assign if1.is_jump_EX = j;
    assign if0.is_jr_EX = jr;     assign if1.is_jr_EX = jr;
    assign if0.is_muldiv_EX = md; assign if1.is_muldiv_EX = md;
    assign if0.reads_hilo_EX = rh; assign if1.reads_hilo_EX = rh;
    assign if0.imem_ready = rdy;  assign if1.imem_ready = rdy;

    fetch_ctrl #(.MULDIV_CYCLES(MC), .CNT_W(6), .DELAY_SLOT(0)) u_ds0 (
        .clk(clk), .rst(rst), .bus(if0));
    fetch_ctrl #(.MULDIV_CYCLES(MC), .CNT_W(6), .DELAY_SLOT(1)) u_ds1 (
        .clk(clk), .rst(rst), .bus(if1));

    // {pc_src, stall, muldiv_start, muldiv_busy, muldiv_done}
    logic [5:0] st0, st1;
    assign st0 = {if0.pc_src, if0.stall, if0.muldiv_start, if0.muldiv_busy, if0.muldiv_done};
    assign st1 = {if1.pc_src, if1.stall, if1.muldiv_start, if1.muldiv_busy, if1.muldiv_done};

    task automatic set_in(input logic [7:0] x);
        {v, br, tk, j, jr, md, rh, rdy} = x;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (st0 !== 6'b0 || st1 !== 6'b0) begin
                errors++;
                $display("FAIL reset_comb k%0d got %b/%b exp 000000", k, st0, st1);
            end
            checks++;
            if (if0.flush_EX !== 1'b0 || if0.stall_count !== 16'd0 || if1.stall_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_regs k%0d flush %b cnt %0d/%0d exp 0", k, if0.flush_EX,
                         if0.stall_count, if1.stall_count);
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (if0.pc_src !== 2'd2 || if1.pc_src !== 2'd2 || if0.stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_release pc_src %0d/%0d stall %b exp 2/2 0", if0.pc_src,
                     if1.pc_src, if0.stall);
        end
        next_cycle();
        set_in(I_IDLE);
        @(negedge clk);
        checks++;
        if (if0.flush_EX !== 1'b1 || if1.flush_EX !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush got %b/%b exp 1/0", if0.flush_EX, if1.flush_EX);
        end
        next_cycle();
    endtask

    task automatic test_redirect();
        logic [7:0] ins [6];
        logic [1:0] epc [6];
        logic       ef  [6];
        ins = '{8'b1110_1001, 8'b1111_0001, I_BRT, 8'b1100_0001, 8'b0001_0001, I_V};
        epc = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
        ef  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            set_in(ins[k]);
            @(negedge clk);
            checks++;
            if (if0.pc_src !== epc[k] || if1.pc_src !== epc[k] || if0.stall !== 1'b0) begin
                errors++;
                $display("FAIL redirect_pc k%0d got %0d/%0d stall %b exp %0d", k, if0.pc_src,
                         if1.pc_src, if0.stall, epc[k]);
            end
            checks++;
            if (if0.flush_EX !== 1'b0) begin
                errors++;
                $display("FAIL redirect_flush_pre k%0d got %b exp 0", k, if0.flush_EX);
            end
            next_cycle();
            set_in(I_IDLE);
            @(negedge clk);
            checks++;
            if (if0.flush_EX !== ef[k] || if1.flush_EX !== 1'b0) begin
                errors++;
                $display("FAIL redirect_flush k%0d got %b/%b exp %b/0", k, if0.flush_EX,
                         if1.flush_EX, ef[k]);
            end
            next_cycle();
        end
    endtask

    task automatic test_muldiv();
        logic [7:0]  ins [6];
        logic [5:0]  es  [6];
        logic [15:0] base;
        ins = '{I_MD, I_V, I_RH, I_RH, I_RH, I_RH};
        es  = '{6'b000100, 6'b000010, 6'b001010, 6'b001010, 6'b001011, 6'b000000};
        base = 16'd0;
        for (int k = 0; k < 6; k++) begin
            set_in(ins[k]);
            @(negedge clk);
            if (k == 0) base = if0.stall_count;
            checks++;
            if (st0 !== es[k] || st1 !== es[k]) begin
                errors++;
                $display("FAIL muldiv_timing c%0d got %b/%b exp %b", k, st0, st1, es[k]);
            end
            if (k == 5) begin
                checks++;
                if (if0.stall_count !== base + 16'd3 || if1.stall_count !== base + 16'd3) begin
                    errors++;
                    $display("FAIL muldiv_stall_count got %0d/%0d exp %0d", if0.stall_count,
                             if1.stall_count, base + 16'd3);
                end
            end
            next_cycle();
        end
        set_in(I_IDLE);
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [5:0]  es [11];
        logic [15:0] base;
        es = '{6'b000100, 6'b001010, 6'b001010, 6'b001010, 6'b001011, 6'b000100,
               6'b000010, 6'b000010, 6'b000010, 6'b000011, 6'b000000};
        base = 16'd0;
        for (int k = 0; k < 11; k++) begin
            set_in(k < 6 ? I_MD : I_IDLE);
            @(negedge clk);
            if (k == 0) base = if0.stall_count;
            checks++;
            if (st0 !== es[k] || st1 !== es[k]) begin
                errors++;
                $display("FAIL b2b_timing c%0d got %b/%b exp %b", k, st0, st1, es[k]);
            end
            if (k == 5) begin
                checks++;
                if (if0.stall_count !== base + 16'd4) begin
                    errors++;
                    $display("FAIL b2b_stall_count got %0d exp %0d", if0.stall_count, base + 16'd4);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_wait();
        logic [5:0]  es [5];
        logic        ef [5];
        logic [15:0] base;
        es = '{6'b001000, 6'b001000, 6'b001000, 6'b010000, 6'b000000};
        ef = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        base = 16'd0;
        for (int k = 0; k < 5; k++) begin
            set_in(k < 3 ? 8'b1110_0000 : (k == 3 ? I_BRT : I_IDLE));
            @(negedge clk);
            if (k == 0) base = if0.stall_count;
            checks++;
            if (st0 !== es[k] || st1 !== es[k] || if0.flush_EX !== ef[k] || if1.flush_EX !== 1'b0) begin
                errors++;
                $display("FAIL mem_wait c%0d got %b/%b flush %b/%b exp %b flush %b/0", k, st0, st1,
                         if0.flush_EX, if1.flush_EX, es[k], ef[k]);
            end
            if (k == 4) begin
                checks++;
                if (if0.stall_count !== base + 16'd3) begin
                    errors++;
                    $display("FAIL mem_wait_count got %0d exp %0d", if0.stall_count, base + 16'd3);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] es [6];
        es = '{6'b000100, 6'b000010, 6'b000010, 6'b000010, 6'b000011, 6'b000000};
        set_in(I_MD);
        next_cycle();
        set_in(I_IDLE);
        next_cycle();
        @(negedge clk);
        checks++;
        if (if0.muldiv_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre busy %b exp 1", if0.muldiv_busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (st0 !== 6'b0 || st1 !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_abort got %b/%b exp 000000", st0, st1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (st0 !== 6'b0 || st1 !== 6'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet c%0d got %b/%b exp 000000", k, st0, st1);
            end
            next_cycle();
        end
        for (int k = 0; k < 6; k++) begin
            set_in(k == 0 ? I_MD : I_IDLE);
            @(negedge clk);
            checks++;
            if (st0 !== es[k] || st1 !== es[k]) begin
                errors++;
                $display("FAIL reset_mid_restart c%0d got %b/%b exp %b", k, st0, st1, es[k]);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        int  rem, cnt, epc;
        bit  prev_redir, ebusy, estall, estart, edone;
        rem = 0; cnt = 0; prev_redir = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int n = 0; n < 600; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            br  = $urandom_range(0, 1);
            tk  = $urandom_range(0, 1);
            j   = ($urandom_range(0, 3) == 0);
            jr  = ($urandom_range(0, 4) == 0);
            md  = ($urandom_range(0, 5) == 0);
            rh  = ($urandom_range(0, 4) == 0);
            rdy = ($urandom_range(0, 6) != 0);
            // Model: remaining busy cycles of the HI/LO unit, not an FSM.
            ebusy  = (rem > 0);
            estall = !rdy || (v && (rh || md) && ebusy);
            epc    = 0;
            if (!estall && v)
                epc = jr ? 3 : (j ? 2 : ((br && tk) ? 1 : 0));
            estart = !estall && v && md;
            edone  = (rem == 1);
            @(negedge clk);
            checks++;
            if (st0 !== {2'(epc), estall, estart, ebusy, edone} ||
                st1 !== {2'(epc), estall, estart, ebusy, edone}) begin
                errors++;
                $display("FAIL random_ctrl n%0d got %b/%b exp %b", n, st0, st1,
                         {2'(epc), estall, estart, ebusy, edone});
            end
            checks++;
            if (if0.flush_EX !== prev_redir || if1.flush_EX !== 1'b0) begin
                errors++;
                $display("FAIL random_flush n%0d got %b/%b exp %b/0", n, if0.flush_EX,
                         if1.flush_EX, prev_redir);
            end
            checks++;
            if (if0.stall_count !== 16'(cnt) || if1.stall_count !== 16'(cnt)) begin
                errors++;
                $display("FAIL random_count n%0d got %0d/%0d exp %0d", n, if0.stall_count,
                         if1.stall_count, cnt);
            end
            if (estart) rem = MC;
            else if (rem > 0) rem--;
            prev_redir = !estall && v && (epc != 0);
            if (estall && cnt < 65535) cnt++;
            next_cycle();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(I_JMP);
        #2 rst = 1'b0;
        test_reset();
        test_redirect();
        test_muldiv();
        test_back_to_back();
        test_mem_wait();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
